// File: rtl/set_assoc_cache.sv
// Two-way set-associative read cache with word-by-word line refill.
// Uncached (kseg1) accesses and all writes bypass the arrays; a write hit invalidates.
module set_assoc_cache #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int CNT_W = (OFF_W > 2) ? OFF_W - 2 : 1;

    // state       | meaning
    // IDLE        | accept a request or flush
    // LOOKUP      | tag compare; hit returns data, miss picks a victim
    // REFILL_REQ  | fetch word[cnt] of the victim line
    // REFILL_WAIT | store returned word, advance or finish the line
    // UNC_REQ     | issue the uncached read/write
    // UNC_WAIT    | return data; a write hit invalidates its line
    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_WAIT, S_UNC_REQ, S_UNC_WAIT
    } state_t;

    state_t state_q, state_d;

    logic             areq_wr_q, areq_wr_d;
    logic [1:0]       areq_size_q, areq_size_d;
    logic [31:0]      areq_addr_q, areq_addr_d;
    logic [31:0]      areq_wdata_q, areq_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             victim_q, victim_d;
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  valid_d [2];
    logic [SETS-1:0]  lru_q, lru_d;

    logic [TAG_W-1:0] tag_q  [2][SETS];
    logic [31:0]      data_q [2][SETS][LINE_WORDS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [CNT_W-1:0] req_word;
    logic [1:0]       way_hit;
    logic             hit;
    logic             hit_way;
    logic             fill_we;
    logic             tag_we;

    assign req_tag  = areq_addr_q[31 -: TAG_W];
    assign req_idx  = areq_addr_q[OFF_W +: IDX_W];
    assign req_word = CNT_W'((areq_addr_q >> 2) & 32'(LINE_WORDS - 1));

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
        end
        hit     = |way_hit;
        hit_way = !way_hit[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        areq_wr_d    = areq_wr_q;
        areq_size_d  = areq_size_q;
        areq_addr_d  = areq_addr_q;
        areq_wdata_d = areq_wdata_q;
        cnt_d        = cnt_q;
        victim_d     = victim_q;
        valid_d      = valid_q;
        lru_d        = lru_q;
        fill_we      = 1'b0;
        tag_we       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d[0] = '0;
                    valid_d[1] = '0;
                end else if (cpu_req) begin
                    areq_wr_d    = cpu_wr;
                    areq_size_d  = cpu_size;
                    areq_addr_d  = cpu_addr;
                    areq_wdata_d = cpu_wdata;
                    state_d      = (cpu_wr || cpu_addr[31:29] == 3'b101) ? S_UNC_REQ : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    lru_d[req_idx] = ~hit_way;
                    state_d        = S_IDLE;
                end else begin
                    if (!valid_q[0][req_idx]) begin
                        victim_d = 1'b0;
                    end else if (!valid_q[1][req_idx]) begin
                        victim_d = 1'b1;
                    end else begin
                        victim_d = lru_q[req_idx];
                    end
                    valid_d[victim_d][req_idx] = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                if (mem_addr_ok) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_data_ok) begin
                    fill_we = 1'b1;
                    if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                        tag_we = 1'b1;
                        valid_d[victim_q][req_idx] = 1'b1;
                        state_d = S_LOOKUP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_UNC_REQ: begin
                if (mem_addr_ok) state_d = S_UNC_WAIT;
            end
            S_UNC_WAIT: begin
                if (mem_data_ok) begin
                    if (areq_wr_q) begin
                        for (int w = 0; w < 2; w++) begin
                            if (way_hit[w]) valid_d[w][req_idx] = 1'b0;
                        end
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_size    = 2'd0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: cpu_addr_ok = !flush;
                S_LOOKUP: begin
                    if (hit) begin
                        cpu_data_ok = 1'b1;
                        cpu_rdata   = data_q[hit_way][req_idx][req_word];
                    end
                end
                S_REFILL_REQ: begin
                    mem_req  = 1'b1;
                    mem_size = 2'd2;
                    mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}} | (32'(cnt_q) << 2);
                end
                S_UNC_REQ: begin
                    mem_req   = 1'b1;
                    mem_wr    = areq_wr_q;
                    mem_size  = areq_size_q;
                    mem_addr  = areq_addr_q;
                    mem_wdata = areq_wdata_q;
                end
                S_UNC_WAIT: begin
                    if (mem_data_ok) begin
                        cpu_data_ok = 1'b1;
                        cpu_rdata   = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q <= valid_d;
            lru_q   <= lru_d;
            cnt_q   <= cnt_d;
        end
        areq_wr_q    <= areq_wr_d;
        areq_size_q  <= areq_size_d;
        areq_addr_q  <= areq_addr_d;
        areq_wdata_q <= areq_wdata_d;
        victim_q     <= victim_d;
    end

    // Tag/data arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) data_q[victim_q][req_idx][cnt_q] <= mem_rdata;
        if (tag_we)  tag_q[victim_q][req_idx]         <= req_tag;
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: address-echo memory model, rdata scoreboard,
// vector table for the main flows plus hand sequences for flush and reset.
module tb_set_assoc_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [1:0]  cpu_size = 2'd2;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;

    set_assoc_cache #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: addr_ok one cycle after mem_req appears, data_ok two cycles after accept.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } mem_txn_t;

    mem_txn_t    mem_log[$];
    int          m_phase = 0;
    int          m_done  = 0;
    logic [31:0] m_addr  = '0;

    always @(posedge clk) begin
        #2;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (mem_req) m_phase = 1;
                1: begin
                    mem_addr_ok = 1'b1;
                    m_addr      = mem_addr;
                    mem_log.push_back('{mem_addr, mem_wr, mem_size, mem_wdata});
                    m_phase     = 2;
                end
                2: m_phase = 3;
                default: begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = m_addr;
                    m_done++;
                    m_phase     = 0;
                end
            endcase
        end
    end

    // Scoreboard: one entry per accepted request, popped on cpu_data_ok.
    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   dok_count = 0;
    int   dok_cycle = 0;

    always @(negedge clk) begin
        if (cpu_data_ok === 1'b1) begin
            dok_count++;
            dok_cycle = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_ok: actual data_ok rdata 0x%08h, required no response", cpu_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check({mon_e.name, "_rdata"}, cpu_rdata, mon_e.rdata);
            end
        end
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] rdata;
        int          mem_cnt;
        logic        refill;
        logic [31:0] base;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic access(input vec_t v, output int acc_cyc);
        int log0;
        int dok0;
        int n_new;
        bit acc;
        log0    = mem_log.size();
        dok0    = dok_count;
        acc     = 1'b0;
        acc_cyc = -1;
        cpu_wr    = v.wr;
        cpu_size  = v.size;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_req   = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (cpu_addr_ok === 1'b1) begin
                acc     = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back('{v.chk, v.rdata, v.name});
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept: actual no addr_ok in 50 cycles, required addr_ok", v.name);
            return;
        end
        for (int i = 0; i < 300 && dok_count == dok0; i++) @(posedge clk);
        #1;
        if (dok_count == dok0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_data_ok: actual no data_ok in 300 cycles, required data_ok", v.name);
            exp_q.delete();
            return;
        end
        if (v.lat != 0) check({v.name, "_latency"}, 32'(dok_cycle - acc_cyc), 32'(v.lat));
        n_new = mem_log.size() - log0;
        check({v.name, "_mem_count"}, 32'(n_new), 32'(v.mem_cnt));
        for (int i = 0; i < v.mem_cnt && i < n_new; i++) begin
            check({v.name, "_mem_addr"}, mem_log[log0 + i].addr, v.refill ? v.base + 32'(4 * i) : v.base);
            check({v.name, "_mem_wr_size"}, {29'd0, mem_log[log0 + i].wr, mem_log[log0 + i].size},
                  v.refill ? 32'd2 : {29'd0, v.wr, v.size});
            if (v.wr) check({v.name, "_mem_wdata"}, mem_log[log0 + i].wdata, v.wdata);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t fv;
        int   acc_c;
        int   c0;
        int   d0;
        bit   ok;

        vecs[0]  = '{"cold_miss_1004", 1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b1, 32'h0000_1004, 4, 1'b1, 32'h0000_1000, 0};
        vecs[1]  = '{"hit_1008",       1'b0, 2'd2, 32'h0000_1008, 32'h0, 1'b1, 32'h0000_1008, 0, 1'b0, 32'h0,         1};
        vecs[2]  = '{"miss_2000_way1", 1'b0, 2'd2, 32'h0000_2000, 32'h0, 1'b1, 32'h0000_2000, 4, 1'b1, 32'h0000_2000, 0};
        vecs[3]  = '{"hit_1000",       1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_1000, 0, 1'b0, 32'h0,         1};
        vecs[4]  = '{"miss_3000_lru",  1'b0, 2'd2, 32'h0000_3000, 32'h0, 1'b1, 32'h0000_3000, 4, 1'b1, 32'h0000_3000, 0};
        vecs[5]  = '{"hit_1000_kept",  1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_1000, 0, 1'b0, 32'h0,         1};
        vecs[6]  = '{"miss_2000_evict",1'b0, 2'd2, 32'h0000_2000, 32'h0, 1'b1, 32'h0000_2000, 4, 1'b1, 32'h0000_2000, 0};
        vecs[7]  = '{"unc_read_a",     1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 1'b1, 32'hBFC0_0000, 1, 1'b0, 32'hBFC0_0000, 0};
        vecs[8]  = '{"unc_read_b",     1'b0, 2'd2, 32'hBFC0_0000, 32'h0, 1'b1, 32'hBFC0_0000, 1, 1'b0, 32'hBFC0_0000, 0};
        vecs[9]  = '{"write_1006",     1'b1, 2'd1, 32'h0000_1006, 32'h0000_BEEF, 1'b0, 32'h0, 1, 1'b0, 32'h0000_1006, 0};
        vecs[10] = '{"refill_after_wr",1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_1000, 4, 1'b1, 32'h0000_1000, 0};
        vecs[11] = '{"hit_100c",       1'b0, 2'd2, 32'h0000_100C, 32'h0, 1'b1, 32'h0000_100C, 0, 1'b0, 32'h0,         1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_addr_ok", {31'd0, cpu_addr_ok}, 32'd0);
        check("reset_data_ok", {31'd0, cpu_data_ok}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) access(vecs[i], acc_c);

        // Flush blocks acceptance in its own cycle, then the held request goes through and misses.
        cpu_wr   = 1'b0;
        cpu_size = 2'd2;
        cpu_addr = 32'h0000_1000;
        cpu_req  = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_blocks_accept", {31'd0, cpu_addr_ok}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        c0    = cyc;
        fv    = '{"after_flush", 1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_1000, 4, 1'b1, 32'h0000_1000, 0};
        access(fv, acc_c);
        check("flush_next_cycle_accept", 32'(acc_c - c0), 32'd0);

        // Reset in the middle of a refill, after two of four words have returned.
        d0       = m_done;
        cpu_addr = 32'h0000_4000;
        cpu_req  = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cpu_addr_ok === 1'b1) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 200 && m_done < d0 + 2; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_refill_words_before_reset", 32'(m_done - d0), 32'd2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_mem_req", {31'd0, mem_req}, 32'd0);
            check("in_reset_data_ok", {31'd0, cpu_data_ok}, 32'd0);
            check("in_reset_addr_ok", {31'd0, cpu_addr_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_mem_req", {31'd0, mem_req}, 32'd0);
            check("post_reset_data_ok", {31'd0, cpu_data_ok}, 32'd0);
        end
        @(posedge clk);
        #1;
        fv = '{"after_reset", 1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_1000, 4, 1'b1, 32'h0000_1000, 0};
        access(fv, acc_c);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
